dbg_reg_access: RTL and testbench
=================================

Name: dbg_reg_access

Overview:
- Debug-side register access engine that sits directly upstream of the core register file's debug port.
- Accepts abstract commands from the JTAG DTM over a valid/ready channel: read GPR, write GPR, halt, resume.
- Halts the core before any GPR access, then drives the register file's jtag_en/addr/data port. Read data returns on a valid/ready response channel.
- Because the core is halted, the register file's core write port never contends with the debug write.

Parameters:
- DATA_W, 32, GPR data width.
- ADDR_W, 5, GPR index width.
- HALT_TIMEOUT, 255, cycles to wait for halted_i before an error response; must be ≥ 1.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_op_i  in  2  operation: 00 READ, 01 WRITE, 10 HALT, 11 RESUME
- cmd_addr_i  in  ADDR_W  GPR index
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_rdata_o  out  DATA_W  read data; 0 for non-READ ops
- rsp_err_o  out  1  halt timeout error
- halt_req_o  out  1  level request to the core to halt
- halted_i  in  1  core halted status; may be asynchronous to the command flow but is synchronous to clk_i
- jtag_en_o  out  1  register-file debug write enable
- jtag_addr_o  out  ADDR_W  register-file debug address
- jtag_data_o  out  DATA_W  register-file debug write data
- jtag_data_i  in  DATA_W  register-file debug read data; combinational from jtag_addr_o

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE.
  - cmd_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - halt_req_o=0, jtag_en_o=0, jtag_addr_o=0, jtag_data_o=0.
  - Timeout counter=0.
- FSM states: IDLE, HALT_WAIT, ACCESS, RESP.
- IDLE:
  - cmd_ready_o=1 only in IDLE.
  - On accept, latch op, addr and wdata. Set halt_req_o=1 for READ, WRITE and HALT.
  - RESUME: halt_req_o←0 and go to RESP.
  - READ/WRITE/HALT with halted_i already 1: go to ACCESS (HALT skips ACCESS and goes to RESP).
  - Otherwise go to HALT_WAIT and clear the counter.
- HALT_WAIT:
  - Counter increments each cycle.
  - If halted_i=1: go to ACCESS (HALT goes to RESP, err=0).
  - Else if counter==HALT_TIMEOUT-1: go to RESP with err=1. No register access is performed; halt_req_o stays 1.
- ACCESS (exactly one cycle):
  - jtag_addr_o=latched addr.
  - WRITE: jtag_en_o=1 and jtag_data_o=wdata for this cycle only.
  - READ: rsp_rdata_o←jtag_data_i, sampled at the end of this cycle.
  - Then go to RESP.
- RESP:
  - rsp_valid_o=1; the response fields are held stable until rsp_ready_i.
  - On the handshake: go to IDLE and clear rsp_valid_o.
- Latency: accept at cycle T with the core already halted → ACCESS at T+1 → rsp_valid_o at T+2.
- halt_req_o stays 1 after a READ/WRITE/HALT until a RESUME completes. It is a sticky debug session.
- Address 0:
  - A WRITE still pulses jtag_en_o; the register file discards it.
  - A READ returns 0, because the register file returns 0.
- jtag_addr_o and jtag_data_o return to 0 outside ACCESS; jtag_en_o is never high outside ACCESS.
- cmd_valid_i in non-IDLE states is ignored; it is not queued.
- If halted_i falls during ACCESS, the access still completes. Core coherence is the debugger's responsibility.
- rsp_rdata_o is 0 for WRITE, HALT and RESUME, and for an errored READ.

Decomposition:
- Shared package dbg_pkg holds:
  - dbg_op_e enum (READ, WRITE, HALT, RESUME).
  - dbg_state_e enum (IDLE, HALT_WAIT, ACCESS, RESP).
  - DBG_OP_W=2.
- Sub-module dbg_halt_timer: loadable up-counter with a terminal-count flag, parameterised by HALT_TIMEOUT.

Test Plan:
- Core halted: READ addr 5 with jtag_data_i=0xDEADBEEF → ACCESS shows jtag_addr_o=5; rsp_valid_o at T+2 with rsp_rdata_o=0xDEADBEEF, err=0.
- Core halted: WRITE addr 10, wdata 0x12345678 → jtag_en_o high exactly 1 cycle with addr 10 and data 0x12345678; response rdata=0, err=0.
- Core not halted: READ issued, halted_i rises 3 cycles later → halt_req_o=1 from T+1, access occurs after halted_i, response correct.
- halted_i never rises, HALT_TIMEOUT=8 → response after 8 wait cycles with err=1, jtag_en_o never asserted, halt_req_o remains 1.
- RESUME after a WRITE → halt_req_o drops at the cycle after accept; response err=0; cmd_ready_o=0 until the response handshake.
- Response backpressure (rsp_ready_i low for 5 cycles) with reset asserted mid-RESP → all outputs clear to 0 immediately (async), FSM returns to IDLE.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types for the debug register access engine: command opcodes and FSM states.
package dbg_pkg;

  localparam int unsigned DBG_OP_W = 2;

  typedef enum logic [DBG_OP_W-1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_HALT   = 2'b10,
    OP_RESUME = 2'b11
  } dbg_op_e;

  typedef enum logic [1:0] {
    IDLE,
    HALT_WAIT,
    ACCESS,
    RESP
  } dbg_state_e;

  // READ and WRITE are the only ops that reach the register-file port.
  function automatic logic op_is_gpr(input dbg_op_e op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/dbg_halt_timer.sv
// Loadable up-counter that flags when the halt wait has run HALT_TIMEOUT cycles.
module dbg_halt_timer #(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HALT_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/dbg_reg_access.sv
// Debug register access engine: halts the core, then reads/writes a GPR through the
// register file's debug port and returns the result on a valid/ready response channel.
module dbg_reg_access
  import dbg_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [DBG_OP_W-1:0] cmd_op_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                halt_req_o,
  input  logic                halted_i,
  output logic                jtag_en_o,
  output logic [ADDR_W-1:0]   jtag_addr_o,
  output logic [DATA_W-1:0]   jtag_data_o,
  input  logic [DATA_W-1:0]   jtag_data_i
);

  dbg_state_e        state_q, state_d;
  dbg_op_e           op_q, op_d;
  dbg_op_e           cmd_op;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              halt_req_q, halt_req_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              timer_load, timer_inc, timer_tc;
  logic              in_access;

  assign cmd_op = dbg_op_e'(cmd_op_i);

  dbg_halt_timer #(
    .HALT_TIMEOUT(HALT_TIMEOUT)
  ) u_halt_timer (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .load_i (timer_load),
    .inc_i  (timer_inc),
    .tc_o   (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    halt_req_d = halt_req_q;
    timer_load = 1'b0;
    timer_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          rdata_d = '0;
          err_d   = 1'b0;
          if (cmd_op == OP_RESUME) begin
            halt_req_d = 1'b0;
            state_d    = RESP;
          end else begin
            halt_req_d = 1'b1;
            if (halted_i) begin
              state_d = op_is_gpr(cmd_op) ? ACCESS : RESP;
            end else begin
              state_d    = HALT_WAIT;
              timer_load = 1'b1;
            end
          end
        end
      end
      HALT_WAIT: begin
        timer_inc = 1'b1;
        // halted_i wins over the timeout when both land in the same cycle.
        if (halted_i) begin
          state_d = op_is_gpr(op_q) ? ACCESS : RESP;
        end else if (timer_tc) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      ACCESS: begin
        if (op_q == OP_READ) begin
          rdata_d = jtag_data_i;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so ready stays low while reset is held and for the first cycle after.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      halt_req_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      halt_req_q  <= halt_req_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign in_access   = (state_q == ACCESS);
  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign halt_req_o  = halt_req_q;
  assign jtag_en_o   = in_access && (op_q == OP_WRITE);
  assign jtag_addr_o = in_access ? addr_q : '0;
  assign jtag_data_o = (in_access && (op_q == OP_WRITE)) ? wdata_q : '0;

endmodule

// File: tb/tb_dbg_reg_access.sv
// Self-checking bench for dbg_reg_access: transaction-timeline model plus a small register file.
module tb_dbg_reg_access;

  localparam int TO    = 8;
  localparam int NEVER = 1000;
  localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_HT = 2'd2, OP_RS = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        halt_req, halted;
  logic        jtag_en;
  logic [4:0]  jtag_addr;
  logic [31:0] jtag_wdata, jtag_rdata;

  always #5 clk = ~clk;

  dbg_reg_access #(
    .DATA_W      (32),
    .ADDR_W      (5),
    .HALT_TIMEOUT(TO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_addr_i (cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .halt_req_o (halt_req),
    .halted_i   (halted),
    .jtag_en_o  (jtag_en),
    .jtag_addr_o(jtag_addr),
    .jtag_data_o(jtag_wdata),
    .jtag_data_i(jtag_rdata)
  );

  // Register file stand-in: x0 reads as zero, writes to x0 are dropped.
  logic [31:0] rf [32];
  logic        pre_we;
  logic [4:0]  pre_a;
  logic [31:0] pre_d;
  always @(posedge clk) begin
    if (pre_we) rf[pre_a] <= pre_d;
    else if (jtag_en && jtag_addr != 5'd0) rf[jtag_addr] <= jtag_wdata;
  end
  assign jtag_rdata = (jtag_addr == 5'd0) ? 32'd0 : rf[jtag_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model expectations for the current cycle, compared on the falling edge.
  logic        chk_en = 1'b0;
  logic        e_ready, e_valid, e_hreq, e_en, e_err;
  logic [4:0]  e_addr;
  logic [31:0] e_wdata, e_rdata;
  logic        e_rsp;
  logic [31:0] exp_rf [32];
  logic        sess;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      chk("halt_req", 32'(halt_req), 32'(e_hreq));
      chk("jtag_en", 32'(jtag_en), 32'(e_en));
      chk("jtag_addr", 32'(jtag_addr), 32'(e_addr));
      chk("jtag_data", jtag_wdata, e_wdata);
      if (e_rsp) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
    end
  end

  int          cap_first_v, cap_en_cnt;
  logic [4:0]  cap_en_addr;
  logic [31:0] cap_en_data, cap_rdata;
  logic        cap_err, cap_hreq_c1, cap_ready_seen;

  task automatic set_idle_exp();
    e_ready = 1'b1; e_valid = 1'b0; e_hreq = sess; e_en = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_err = 1'b0; e_rsp = 1'b0;
  endtask

  task automatic idle_cycle();
    cmd_valid = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));
    set_idle_exp();
    @(posedge clk); #1;
  endtask

  // h: cycle (relative to accept) from which halted_i is 1; 0 = already halted.
  // bp: cycles the response is held before rsp_ready_i goes high.
  task automatic run_txn(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd,
                         input int h, input int bp);
    int w, acc, rs, r;
    logic err;
    logic [31:0] rd;
    if (op == OP_RS) begin
      err = 1'b0; acc = -1; rs = 1;
    end else begin
      w   = (h == 0) ? 0 : ((h <= TO) ? h : TO);
      err = (h > TO);
      if (op == OP_HT || err) begin
        acc = -1; rs = w + 1;
      end else begin
        acc = w + 1; rs = w + 2;
      end
    end
    r  = rs + bp;
    rd = (op == OP_RD && !err) ? exp_rf[a] : 32'd0;

    cap_first_v = -1; cap_en_cnt = 0; cap_en_addr = '0; cap_en_data = '0;
    cap_rdata = '0; cap_err = 1'b0; cap_hreq_c1 = 1'b0; cap_ready_seen = 1'b0;

    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    halted    = (h == 0);
    rsp_ready = 1'($urandom_range(0, 1));
    set_idle_exp();
    @(posedge clk); #1;
    sess = (op != OP_RS);

    for (int c = 1; c <= r; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_addr  = 5'($urandom);
      cmd_wdata = $urandom;
      halted    = (c >= h);
      rsp_ready = (c < rs) ? 1'($urandom_range(0, 1)) : (c >= r);
      e_ready = 1'b0;
      e_valid = (c >= rs);
      e_hreq  = sess;
      e_en    = (c == acc) && (op == OP_WR);
      e_addr  = (c == acc) ? a : 5'd0;
      e_wdata = ((c == acc) && (op == OP_WR)) ? wd : 32'd0;
      e_rsp   = (c >= rs);
      e_rdata = rd;
      e_err   = err;
      if (rsp_valid && cap_first_v < 0) cap_first_v = c;
      if (cmd_ready) cap_ready_seen = 1'b1;
      if (jtag_en) begin
        cap_en_cnt++; cap_en_addr = jtag_addr; cap_en_data = jtag_wdata;
      end
      if (c == 1) cap_hreq_c1 = halt_req;
      if (c == r) begin
        cap_rdata = rsp_rdata; cap_err = rsp_err;
      end
      @(posedge clk); #1;
    end
    if (op == OP_WR && !err && a != 5'd0) exp_rf[a] = wd;
  endtask

  initial begin
    int k, h;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; halted = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    sess = 1'b0;
    set_idle_exp();

    for (int i = 0; i < 32; i++) begin
      pre_we = 1'b1;
      pre_a  = 5'(i);
      pre_d  = (i == 5) ? 32'hDEADBEEF : $urandom;
      exp_rf[i] = (i == 0) ? 32'd0 : pre_d;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_halt_req", 32'(halt_req), 32'd0);
    chk("rst_jtag_en", 32'(jtag_en), 32'd0);
    chk("rst_jtag_addr", 32'(jtag_addr), 32'd0);
    chk("rst_jtag_data", jtag_wdata, 32'd0);

    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    run_txn(OP_RD, 5'd5, 32'd0, 0, 0);
    chk("rd5_latency", cap_first_v, 2);
    chk("rd5_rdata", cap_rdata, 32'hDEADBEEF);
    chk("rd5_err", 32'(cap_err), 32'd0);
    chk("rd5_no_write", cap_en_cnt, 0);

    run_txn(OP_WR, 5'd10, 32'h12345678, 0, 2);
    chk("wr10_en_cycles", cap_en_cnt, 1);
    chk("wr10_en_addr", 32'(cap_en_addr), 32'd10);
    chk("wr10_en_data", cap_en_data, 32'h12345678);
    chk("wr10_rdata", cap_rdata, 32'd0);
    chk("wr10_err", 32'(cap_err), 32'd0);

    run_txn(OP_RD, 5'd10, 32'd0, 0, 1);
    chk("rd10_rdata", cap_rdata, 32'h12345678);

    run_txn(OP_WR, 5'd0, 32'hCAFEF00D, 0, 0);
    chk("wr0_en_cycles", cap_en_cnt, 1);
    run_txn(OP_RD, 5'd0, 32'd0, 0, 0);
    chk("rd0_rdata", cap_rdata, 32'd0);

    run_txn(OP_RS, 5'd0, 32'd0, 0, 3);
    chk("resume_hreq_c1", 32'(cap_hreq_c1), 32'd0);
    chk("resume_ready_low", 32'(cap_ready_seen), 32'd0);
    chk("resume_latency", cap_first_v, 1);
    chk("resume_err", 32'(cap_err), 32'd0);

    run_txn(OP_RD, 5'd5, 32'd0, 3, 0);
    chk("rdwait_hreq_c1", 32'(cap_hreq_c1), 32'd1);
    chk("rdwait_latency", cap_first_v, 5);
    chk("rdwait_rdata", cap_rdata, 32'hDEADBEEF);

    run_txn(OP_RD, 5'd5, 32'd0, NEVER, 1);
    chk("tmo_latency", cap_first_v, TO + 1);
    chk("tmo_err", 32'(cap_err), 32'd1);
    chk("tmo_rdata", cap_rdata, 32'd0);
    chk("tmo_no_en", cap_en_cnt, 0);
    idle_cycle();
    chk("tmo_hreq_kept", 32'(halt_req), 32'd1);

    run_txn(OP_WR, 5'd3, 32'hA5A5_0001, TO, 0);
    chk("edge_to_latency", cap_first_v, TO + 2);
    chk("edge_to_err", 32'(cap_err), 32'd0);
    chk("edge_to_en", cap_en_cnt, 1);
    run_txn(OP_WR, 5'd3, 32'hA5A5_0002, TO + 1, 0);
    chk("edge_to1_latency", cap_first_v, TO + 1);
    chk("edge_to1_err", 32'(cap_err), 32'd1);
    chk("edge_to1_en", cap_en_cnt, 0);

    run_txn(OP_HT, 5'd0, 32'd0, 2, 0);
    chk("halt_latency", cap_first_v, 3);
    chk("halt_err", 32'(cap_err), 32'd0);

    // Backpressured response interrupted by an asynchronous reset.
    chk_en = 1'b0;
    halted = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RD; cmd_addr = 5'd5; rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_valid_held", 32'(rsp_valid), 32'd1);
    chk("bp_rdata_held", rsp_rdata, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_rsp_rdata", rsp_rdata, 32'd0);
    chk("arst_halt_req", 32'(halt_req), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("arst_jtag_addr", 32'(jtag_addr), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_back_idle", 32'(cmd_ready), 32'd1);
    sess = 1'b0;
    chk_en = 1'b1;

    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      k = int'($urandom_range(0, 7));
      case (k)
        0, 1:    h = 0;
        2:       h = 1;
        3:       h = int'($urandom_range(2, 4));
        4:       h = TO - 1;
        5:       h = TO;
        6:       h = TO + 1;
        default: h = NEVER;
      endcase
      run_txn(2'($urandom_range(0, 3)), 5'($urandom), $urandom, h, int'($urandom_range(0, 4)));
    end

    // Read back every GPR so any corrupted write surfaces.
    for (int i = 0; i < 32; i++) run_txn(OP_RD, 5'(i), 32'd0, 0, 0);

    idle_cycle();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
